// File: rtl/calendar_pkg.sv
// ============================================================================
// Module  : calendar_pkg
// Purpose : Month/weekday codes and Gregorian calendar helper functions.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package calendar_pkg;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_MAR = 4'd3;
  localparam logic [3:0] MONTH_APR = 4'd4;
  localparam logic [3:0] MONTH_MAY = 4'd5;
  localparam logic [3:0] MONTH_JUN = 4'd6;
  localparam logic [3:0] MONTH_JUL = 4'd7;
  localparam logic [3:0] MONTH_AUG = 4'd8;
  localparam logic [3:0] MONTH_SEP = 4'd9;
  localparam logic [3:0] MONTH_OCT = 4'd10;
  localparam logic [3:0] MONTH_NOV = 4'd11;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  localparam logic [2:0] DOW_MON = 3'd0;
  localparam logic [2:0] DOW_TUE = 3'd1;
  localparam logic [2:0] DOW_WED = 3'd2;
  localparam logic [2:0] DOW_THU = 3'd3;
  localparam logic [2:0] DOW_FRI = 3'd4;
  localparam logic [2:0] DOW_SAT = 3'd5;
  localparam logic [2:0] DOW_SUN = 3'd6;

  function automatic logic is_leap(input logic [11:0] year);
    return ((year[1:0] == 2'b00) && ((year % 12'd100) != 12'd0)) ||
           ((year % 12'd400) == 12'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [11:0] year);
    logic [4:0] dim;
    case (month)
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: dim = 5'd30;
      MONTH_FEB: dim = is_leap(year) ? 5'd29 : 5'd28;
      default:   dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd4.sv
// ============================================================================
// Module  : bin_to_bcd4
// Purpose : Combinational 12-bit binary to four-digit BCD (shift-add-3).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bin_to_bcd4 (
  input  logic [11:0] i_bin,
  output logic [3:0]  o_bcd_1s,
  output logic [3:0]  o_bcd_10s,
  output logic [3:0]  o_bcd_100s,
  output logic [3:0]  o_bcd_1000s
);

  // BCD digits live in bits [27:12]; the binary operand shifts out of [11:0].
  logic [27:0] w_shift;

  always_comb begin
    w_shift = {16'd0, i_bin};
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (w_shift[12 + 4*d +: 4] >= 4'd5) begin
          w_shift[12 + 4*d +: 4] = w_shift[12 + 4*d +: 4] + 4'd3;
        end
      end
      w_shift = w_shift << 1;
    end
  end

  assign o_bcd_1s    = w_shift[15:12];
  assign o_bcd_10s   = w_shift[19:16];
  assign o_bcd_100s  = w_shift[23:20];
  assign o_bcd_1000s = w_shift[27:24];

endmodule

`default_nettype wire

// File: rtl/calendar_date.sv
// ============================================================================
// Module  : calendar_date
// Purpose : Day/month/year calendar advanced at midnight, with manual set
//           buttons and BCD outputs. Optional weekday via DAY_OF_WEEK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calendar_date
  import calendar_pkg::*;
#(
  parameter int unsigned YEAR_RESET = 2000,
  parameter int unsigned YEAR_MIN   = 2000,
  parameter int unsigned YEAR_MAX   = 2099
) (
  input  logic        clk_1hz,
  input  logic        time_reset,
  input  logic [4:0]  hour_in,
  input  logic        date_set,
  input  logic        day_inc,
  input  logic        day_dec,
  input  logic        month_inc,
  input  logic        month_dec,
  input  logic        year_inc,
  input  logic        year_dec,
  input  logic        dow_inc,
  output logic [4:0]  day_out,
  output logic [3:0]  month_out,
  output logic [11:0] year_out,
  output logic        date_rollover,
  output logic [3:0]  day_1s,
  output logic [3:0]  day_10s,
  output logic [3:0]  mon_1s,
  output logic [3:0]  mon_10s,
  output logic [3:0]  yr_1s,
  output logic [3:0]  yr_10s,
  output logic [3:0]  yr_100s,
  output logic [3:0]  yr_1000s,
  output logic [2:0]  dow_out
);

  localparam logic [11:0] c_year_reset = 12'(YEAR_RESET);
  localparam logic [11:0] c_year_min   = 12'(YEAR_MIN);
  localparam logic [11:0] c_year_max   = 12'(YEAR_MAX);

  logic [4:0]  r_prev_hour;
  logic [4:0]  r_day;
  logic [3:0]  r_month;
  logic [11:0] r_year;
  logic        r_rollover;

  logic        w_midnight;
  logic [4:0]  w_dim_cur;
  logic [11:0] w_year_up;
  logic [11:0] w_year_dn;
  logic [4:0]  w_day_nxt;
  logic [3:0]  w_month_nxt;
  logic [11:0] w_year_nxt;
  logic [4:0]  w_dim_nxt;
  logic        w_rollover_nxt;

  assign w_midnight = (r_prev_hour == 5'd23) && (hour_in == 5'd0);
  assign w_dim_cur  = days_in_month(r_month, r_year);
  assign w_year_up  = (r_year >= c_year_max) ? c_year_min : r_year + 12'd1;
  assign w_year_dn  = (r_year <= c_year_min) ? c_year_max : r_year - 12'd1;

  always_comb begin
    w_day_nxt      = r_day;
    w_month_nxt    = r_month;
    w_year_nxt     = r_year;
    w_rollover_nxt = 1'b0;
    if (!date_set) begin
      if (w_midnight) begin
        w_rollover_nxt = 1'b1;
        if (r_day < w_dim_cur) begin
          w_day_nxt = r_day + 5'd1;
        end else begin
          w_day_nxt = 5'd1;
          if (r_month == MONTH_DEC) begin
            w_month_nxt = MONTH_JAN;
            w_year_nxt  = w_year_up;
          end else begin
            w_month_nxt = r_month + 4'd1;
          end
        end
      end
    end else if (day_inc) begin
      w_day_nxt = (r_day >= w_dim_cur) ? 5'd1 : r_day + 5'd1;
    end else if (day_dec) begin
      w_day_nxt = (r_day <= 5'd1) ? w_dim_cur : r_day - 5'd1;
    end else if (month_inc) begin
      w_month_nxt = (r_month == MONTH_DEC) ? MONTH_JAN : r_month + 4'd1;
    end else if (month_dec) begin
      w_month_nxt = (r_month == MONTH_JAN) ? MONTH_DEC : r_month - 4'd1;
    end else if (year_inc) begin
      w_year_nxt = w_year_up;
    end else if (year_dec) begin
      w_year_nxt = w_year_dn;
    end
    // Keep the day legal when the month or year moves under it.
    w_dim_nxt = days_in_month(w_month_nxt, w_year_nxt);
    if (w_day_nxt > w_dim_nxt) begin
      w_day_nxt = w_dim_nxt;
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (time_reset) begin
      r_prev_hour <= 5'd0;
      r_day       <= 5'd1;
      r_month     <= MONTH_JAN;
      r_year      <= c_year_reset;
      r_rollover  <= 1'b0;
    end else begin
      r_prev_hour <= hour_in;
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_rollover  <= w_rollover_nxt;
    end
  end

  assign day_out       = r_day;
  assign month_out     = r_month;
  assign year_out      = r_year;
  assign date_rollover = r_rollover;

`ifdef DAY_OF_WEEK_EN
  logic [2:0] r_dow;
  logic       w_dow_step;

  // Manual weekday stepping only when no date button claims the edge.
  assign w_dow_step = date_set
                    ? (dow_inc && !(day_inc || day_dec || month_inc ||
                                    month_dec || year_inc || year_dec))
                    : w_midnight;

  always_ff @(posedge clk_1hz) begin
    if (time_reset) begin
      r_dow <= DOW_MON;
    end else if (w_dow_step) begin
      r_dow <= (r_dow == DOW_SUN) ? DOW_MON : r_dow + 3'd1;
    end
  end

  assign dow_out = r_dow;
`else
  logic w_unused_dow_inc;
  assign w_unused_dow_inc = dow_inc;
  assign dow_out          = 3'd0;
`endif

  logic [3:0] w_unused_day_100s;
  logic [3:0] w_unused_day_1000s;
  logic [3:0] w_unused_mon_100s;
  logic [3:0] w_unused_mon_1000s;

  bin_to_bcd4 u_bcd_day (
    .i_bin       ({7'd0, r_day}),
    .o_bcd_1s    (day_1s),
    .o_bcd_10s   (day_10s),
    .o_bcd_100s  (w_unused_day_100s),
    .o_bcd_1000s (w_unused_day_1000s)
  );

  bin_to_bcd4 u_bcd_month (
    .i_bin       ({8'd0, r_month}),
    .o_bcd_1s    (mon_1s),
    .o_bcd_10s   (mon_10s),
    .o_bcd_100s  (w_unused_mon_100s),
    .o_bcd_1000s (w_unused_mon_1000s)
  );

  bin_to_bcd4 u_bcd_year (
    .i_bin       (r_year),
    .o_bcd_1s    (yr_1s),
    .o_bcd_10s   (yr_10s),
    .o_bcd_100s  (yr_100s),
    .o_bcd_1000s (yr_1000s)
  );

endmodule

`default_nettype wire

// File: tb/tb_calendar_date.sv
// ============================================================================
// Module  : tb_calendar_date
// Purpose : Self-checking bench for calendar_date (two instances, YEAR_MAX
//           2099 and 2199) against a calendar reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calendar_date;

  logic       clk_1hz = 1'b0;
  logic       time_reset = 1'b1;
  logic [4:0] hour_in = 5'd0;
  logic       date_set = 1'b0;
  logic       day_inc = 1'b0, day_dec = 1'b0, month_inc = 1'b0, month_dec = 1'b0;
  logic       year_inc = 1'b0, year_dec = 1'b0, dow_inc = 1'b0;

  logic [4:0]  day_o  [2];
  logic [3:0]  mon_o  [2];
  logic [11:0] year_o [2];
  logic        roll_o [2];
  logic [2:0]  dow_o  [2];
  logic [3:0]  bcd_o  [2][8];

  int checks = 0;
  int failures = 0;

  always #5 clk_1hz = ~clk_1hz;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    calendar_date #(
      .YEAR_RESET (2000),
      .YEAR_MIN   (2000),
      .YEAR_MAX   ((k == 0) ? 2099 : 2199)
    ) u_dut (
      .clk_1hz       (clk_1hz),
      .time_reset    (time_reset),
      .hour_in       (hour_in),
      .date_set      (date_set),
      .day_inc       (day_inc),
      .day_dec       (day_dec),
      .month_inc     (month_inc),
      .month_dec     (month_dec),
      .year_inc      (year_inc),
      .year_dec      (year_dec),
      .dow_inc       (dow_inc),
      .day_out       (day_o[k]),
      .month_out     (mon_o[k]),
      .year_out      (year_o[k]),
      .date_rollover (roll_o[k]),
      .day_1s        (bcd_o[k][0]),
      .day_10s       (bcd_o[k][1]),
      .mon_1s        (bcd_o[k][2]),
      .mon_10s       (bcd_o[k][3]),
      .yr_1s         (bcd_o[k][4]),
      .yr_10s        (bcd_o[k][5]),
      .yr_100s       (bcd_o[k][6]),
      .yr_1000s      (bcd_o[k][7]),
      .dow_out       (dow_o[k])
    );
  end

  // Reference model: plain calendar arithmetic per instance.
  int m_day [2], m_mon [2], m_year [2], m_prev [2], m_dow [2];
  bit m_roll [2];
  int ymax [2] = '{2099, 2199};

  function automatic int dim_f(input int m, input int y);
    int t [12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0))) return 29;
    return t[m-1];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (time_reset) begin
        m_day[k] = 1; m_mon[k] = 1; m_year[k] = 2000;
        m_prev[k] = 0; m_roll[k] = 0; m_dow[k] = 0;
      end else begin
        m_roll[k] = 0;
        if (!date_set) begin
          if (m_prev[k] == 23 && hour_in == 0) begin
            m_roll[k] = 1;
`ifdef DAY_OF_WEEK_EN
            m_dow[k] = (m_dow[k] + 1) % 7;
`endif
            if (m_day[k] < dim_f(m_mon[k], m_year[k])) m_day[k]++;
            else begin
              m_day[k] = 1;
              if (m_mon[k] < 12) m_mon[k]++;
              else begin
                m_mon[k] = 1;
                m_year[k] = (m_year[k] == ymax[k]) ? 2000 : m_year[k] + 1;
              end
            end
          end
        end else begin
          if (day_inc)        m_day[k] = m_day[k] % dim_f(m_mon[k], m_year[k]) + 1;
          else if (day_dec)   m_day[k] = (m_day[k] == 1) ? dim_f(m_mon[k], m_year[k]) : m_day[k] - 1;
          else if (month_inc) m_mon[k] = m_mon[k] % 12 + 1;
          else if (month_dec) m_mon[k] = (m_mon[k] == 1) ? 12 : m_mon[k] - 1;
          else if (year_inc)  m_year[k] = (m_year[k] == ymax[k]) ? 2000 : m_year[k] + 1;
          else if (year_dec)  m_year[k] = (m_year[k] == 2000) ? ymax[k] : m_year[k] - 1;
`ifdef DAY_OF_WEEK_EN
          else if (dow_inc)   m_dow[k] = (m_dow[k] + 1) % 7;
`endif
          if (m_day[k] > dim_f(m_mon[k], m_year[k])) m_day[k] = dim_f(m_mon[k], m_year[k]);
        end
        m_prev[k] = int'(hour_in);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    model_step();
    #1;
  endtask

  task automatic release_buttons();
    day_inc = 0; day_dec = 0; month_inc = 0; month_dec = 0;
    year_inc = 0; year_dec = 0; dow_inc = 0;
  endtask

  // Reset, then walk the buttons to the requested date; leaves set mode on.
  task automatic goto_date(input int y, input int m, input int d);
    release_buttons();
    hour_in = 0; date_set = 1; time_reset = 1;
    tick();
    time_reset = 0;
    year_inc = 1;  repeat (y - 2000) tick(); year_inc = 0;
    month_inc = 1; repeat (m - 1) tick();    month_inc = 0;
    day_inc = 1;   repeat (d - 1) tick();    day_inc = 0;
  endtask

  task automatic midnight();
    date_set = 0;
    hour_in = 23; tick();
    hour_in = 0;  tick();
  endtask

  task automatic test_reset();
    date_set = 1; day_inc = 1; year_inc = 1; hour_in = 23; time_reset = 1;
    tick();
    time_reset = 0; release_buttons();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({day_o[k], mon_o[k], year_o[k]} !== {5'd1, 4'd1, 12'd2000}) begin
        failures++;
        $display("FAIL reset_date dut%0d got %0d-%0d-%0d want 2000-1-1", k, year_o[k], mon_o[k], day_o[k]);
      end
      checks++;
      if ({roll_o[k], dow_o[k]} !== 4'b0) begin
        failures++;
        $display("FAIL reset_flags dut%0d got roll=%0b dow=%0d want 0/0", k, roll_o[k], dow_o[k]);
      end
      checks++;
      if ({bcd_o[k][7], bcd_o[k][6], bcd_o[k][5], bcd_o[k][4], bcd_o[k][3], bcd_o[k][2], bcd_o[k][1], bcd_o[k][0]} !== 32'h2000_0101) begin
        failures++;
        $display("FAIL reset_bcd dut%0d got %h%h%h%h %h%h %h%h want 2000 01 01", k,
                 bcd_o[k][7], bcd_o[k][6], bcd_o[k][5], bcd_o[k][4], bcd_o[k][3], bcd_o[k][2], bcd_o[k][1], bcd_o[k][0]);
      end
    end
  endtask

  task automatic test_midnight();
    goto_date(2000, 1, 31);
    date_set = 0; hour_in = 23; tick();
    checks++;
    if ({roll_o[0], day_o[0], mon_o[0]} !== {1'b0, 5'd31, 4'd1}) begin
      failures++;
      $display("FAIL pre_midnight got roll=%0b %0d/%0d want 0 31/1", roll_o[0], day_o[0], mon_o[0]);
    end
    hour_in = 0; tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({roll_o[k], day_o[k], mon_o[k], year_o[k]} !== {1'b1, 5'd1, 4'd2, 12'd2000}) begin
        failures++;
        $display("FAIL midnight_adv dut%0d got roll=%0b %0d-%0d-%0d want 1 2000-2-1", k, roll_o[k], year_o[k], mon_o[k], day_o[k]);
      end
    end
    tick();
    checks++;
    if ({roll_o[0], day_o[0], mon_o[0]} !== {1'b0, 5'd1, 4'd2}) begin
      failures++;
      $display("FAIL pulse_width got roll=%0b %0d/%0d want 0 1/2", roll_o[0], day_o[0], mon_o[0]);
    end
  endtask

  task automatic test_leap();
    int ys [3] = '{2000, 2024, 2100};
    int ed [3] = '{29, 29, 1};
    int em [3] = '{2, 2, 3};
    for (int i = 0; i < 3; i++) begin
      goto_date(ys[i], 2, 28);
      midnight();
      checks++;
      if ({day_o[1], mon_o[1], year_o[1]} !== {5'(ed[i]), 4'(em[i]), 12'(ys[i])}) begin
        failures++;
        $display("FAIL leap_%0d got %0d-%0d-%0d want %0d-%0d-%0d", ys[i], year_o[1], mon_o[1], day_o[1], ys[i], em[i], ed[i]);
      end
      checks++;
      if ({day_o[0], mon_o[0], year_o[0]} !== {5'(m_day[0]), 4'(m_mon[0]), 12'(m_year[0])}) begin
        failures++;
        $display("FAIL leap_%0d_dut0 got %0d-%0d-%0d want %0d-%0d-%0d", ys[i], year_o[0], mon_o[0], day_o[0], m_year[0], m_mon[0], m_day[0]);
      end
    end
  endtask

  task automatic test_year_wrap();
    goto_date(2099, 12, 31);
    midnight();
    checks++;
    if ({roll_o[0], day_o[0], mon_o[0], year_o[0]} !== {1'b1, 5'd1, 4'd1, 12'd2000}) begin
      failures++;
      $display("FAIL year_wrap_auto got roll=%0b %0d-%0d-%0d want 1 2000-1-1", roll_o[0], year_o[0], mon_o[0], day_o[0]);
    end
    checks++;
    if ({day_o[1], mon_o[1], year_o[1]} !== {5'd1, 4'd1, 12'd2100}) begin
      failures++;
      $display("FAIL year_nowrap_2199 got %0d-%0d-%0d want 2100-1-1", year_o[1], mon_o[1], day_o[1]);
    end
    goto_date(2000, 1, 1);
    year_dec = 1; tick(); year_dec = 0;
    checks++;
    if ({year_o[0], year_o[1]} !== {12'd2099, 12'd2199}) begin
      failures++;
      $display("FAIL year_dec_wrap got %0d/%0d want 2099/2199", year_o[0], year_o[1]);
    end
  endtask

  task automatic test_clamp();
    for (int y = 2023; y <= 2024; y++) begin
      goto_date(y, 3, 31);
      month_dec = 1; tick(); month_dec = 0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({day_o[k], mon_o[k], year_o[k]} !== {((y == 2024) ? 5'd29 : 5'd28), 4'd2, 12'(y)}) begin
          failures++;
          $display("FAIL clamp_%0d dut%0d got %0d-%0d-%0d want Feb %0d", y, k, year_o[k], mon_o[k], day_o[k], (y == 2024) ? 29 : 28);
        end
      end
    end
  endtask

  task automatic test_priority();
    goto_date(2000, 4, 30);
    hour_in = 23; tick();
    day_inc = 1; month_inc = 1; hour_in = 0; tick();
    release_buttons();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({roll_o[k], day_o[k], mon_o[k], year_o[k]} !== {1'b0, 5'd1, 4'd4, 12'd2000}) begin
        failures++;
        $display("FAIL set_priority dut%0d got roll=%0b %0d-%0d-%0d want 0 2000-4-1", k, roll_o[k], year_o[k], mon_o[k], day_o[k]);
      end
    end
  endtask

  task automatic test_reset_mid_set();
    goto_date(2024, 7, 15);
    day_inc = 1; day_dec = 1; month_inc = 1; month_dec = 1;
    year_inc = 1; year_dec = 1; dow_inc = 1; time_reset = 1;
    tick();
    time_reset = 0; release_buttons();
    checks++;
    if ({day_o[0], mon_o[0], year_o[0], dow_o[0]} !== {5'd1, 4'd1, 12'd2000, 3'd0}) begin
      failures++;
      $display("FAIL reset_mid_set got %0d-%0d-%0d dow=%0d want 2000-1-1 dow=0", year_o[0], mon_o[0], day_o[0], dow_o[0]);
    end
  endtask

  task automatic test_dow();
    int exp_dow;
    goto_date(2000, 1, 1);
    for (int i = 1; i <= 7; i++) begin
      midnight();
`ifdef DAY_OF_WEEK_EN
      exp_dow = i % 7;
`else
      exp_dow = 0;
`endif
      checks++;
      if (dow_o[0] !== 3'(exp_dow) || dow_o[1] !== 3'(exp_dow)) begin
        failures++;
        $display("FAIL dow_step_%0d got %0d/%0d want %0d", i, dow_o[0], dow_o[1], exp_dow);
      end
    end
  endtask

  task automatic test_random();
    logic [56:0] got, exp;
    goto_date(2000, 1, 1);
    for (int n = 0; n < 2000; n++) begin
      time_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) date_set = ~date_set;
      case ($urandom_range(0, 3))
        0: hour_in = 5'd23;
        1: hour_in = 5'd0;
        2: hour_in = 5'($urandom_range(0, 23));
        default: ;
      endcase
      day_inc   = ($urandom_range(0, 5) == 0);
      day_dec   = ($urandom_range(0, 5) == 0);
      month_inc = ($urandom_range(0, 5) == 0);
      month_dec = ($urandom_range(0, 5) == 0);
      year_inc  = ($urandom_range(0, 3) == 0);
      year_dec  = ($urandom_range(0, 7) == 0);
      dow_inc   = ($urandom_range(0, 2) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        got = {day_o[k], mon_o[k], year_o[k], roll_o[k], dow_o[k],
               bcd_o[k][0], bcd_o[k][1], bcd_o[k][2], bcd_o[k][3],
               bcd_o[k][4], bcd_o[k][5], bcd_o[k][6], bcd_o[k][7]};
        exp = {5'(m_day[k]), 4'(m_mon[k]), 12'(m_year[k]), m_roll[k], 3'(m_dow[k]),
               4'(m_day[k] % 10), 4'(m_day[k] / 10), 4'(m_mon[k] % 10), 4'(m_mon[k] / 10),
               4'(m_year[k] % 10), 4'((m_year[k] / 10) % 10), 4'((m_year[k] / 100) % 10), 4'(m_year[k] / 1000)};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL random_%0d dut%0d got %h want %h (model %0d-%0d-%0d)", n, k, got, exp, m_year[k], m_mon[k], m_day[k]);
        end
      end
    end
    time_reset = 0; release_buttons();
  endtask

  initial begin
    test_reset();
    test_midnight();
    test_leap();
    test_year_wrap();
    test_clamp();
    test_priority();
    test_reset_mid_set();
    test_dow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
